// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs between instruction memory and decode.
// Flush has priority over push and pop. Head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // Entry storage; contents only matter while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order req/gnt/rvalid
// requests, buffers responses in fetch_fifo and presents them to decode.
// Credits: a request is only issued while in-flight + buffered < DEPTH, so the
// FIFO can never overflow. On redirect every response still in flight is
// counted into discard and dropped when it returns.
// Optional: define FETCH_PERF_CNT_EN to add bubble and redirect counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt_o,
    output logic [31:0] perf_redirect_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [XLEN-1:0] last_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            run_q;
    logic            gnt_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Request/credit logic. run_q keeps req low while rst_n is asserted.
    assign credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_o       = run_q && (credit_used < (CW+1)'(DEPTH)) && !redirect_i;
    assign imem_addr_o      = fetch_pc_q;
    assign gnt_fire         = imem_req_o && imem_gnt_i;
    assign outstanding_next = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);

    assign fifo_push  = imem_rvalid_i && (discard_q == '0) && !redirect_i;
    assign fifo_pop   = if_valid_o && if_ready_i && !redirect_i;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .flush_i (redirect_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign if_valid_o = !fifo_empty;
    assign if_pc_o    = if_valid_o ? head.pc : last_pc_q;
    assign if_instr_o = if_valid_o ? head.instr : NOP_INSTR;

    // PC tracking, in-flight and discard counters; redirect overrides all.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_next;
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc_i;
                resp_pc_q  <= redirect_pc_i;
                discard_q  <= outstanding_next;
            end else begin
                if (gnt_fire)  fetch_pc_q <= fetch_pc_q + 32'd4;
                if (fifo_push) resp_pc_q  <= resp_pc_q + 32'd4;
                if (imem_rvalid_i && (discard_q != '0)) discard_q <= discard_q - CW'(1);
            end
        end
    end

    // Remember the last presented PC so if_pc_o holds while the FIFO is empty.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q <= '0;
        end else if (if_valid_o) begin
            last_pc_q <= head.pc;
        end
    end

    push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(fifo_push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
    // Bubble cycles (decode ready, nothing to give) and redirect cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt_o   <= '0;
            perf_redirect_cnt_o <= '0;
        end else begin
            if (!if_valid_o && if_ready_i) perf_bubble_cnt_o   <= perf_bubble_cnt_o + 32'd1;
            if (redirect_i)                perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized run, checked against a sequence-level model of the fetch stream.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i = 1'b0;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          popped = 0;
    int          grants = 0;
    int          buffered = 0;
    logic [31:0] exp_pc;
    logic [31:0] fpc_m;
    bit          first_cycle;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          redir = 0;
    logic [31:0] redir_pc = '0;
    bit          rdy = 1;
    int          gnt_force = 1;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory/decode inputs, check outputs against the
    // stream model, then advance the model past the rising edge.
    task automatic cycle();
        bit rv;
        bit exp_req;
        imem_gnt_i    = (gnt_force < 0) ? ($urandom_range(0, 1) == 1) : (gnt_force != 0);
        rv            = (q.size() > 0) && (q[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? memdata(q[0].addr) : $urandom;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        if_ready_i    = rdy;
        #1;
        exp_req = !redir && ((q.size() + buffered) < DEPTH);
        if (!first_cycle) check("req", imem_req_o, exp_req);
        if (prev_stall && !redir) check("addr_hold", imem_addr_o, prev_addr);
        check("valid", if_valid_o, buffered != 0);
        if (!if_valid_o) check("idle_instr", if_instr_o, NOP);
        if (if_valid_o && rdy && !redir) begin
            check("pop_pc", if_pc_o, exp_pc);
            check("pop_instr", if_instr_o, memdata(exp_pc));
            exp_pc += 32'd4;
            popped++;
            if (buffered > 0) buffered--;
        end
        if (rv) begin
            if (!q[0].stale && !redir) buffered++;
            void'(q.pop_front());
        end
        if (imem_req_o && imem_gnt_i) begin
            check("gnt_addr", imem_addr_o, fpc_m);
            fpc_m += 32'd4;
            grants++;
            q.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(lat_min, lat_max)), stale: 1'b0});
        end
        if (redir) begin
            buffered = 0;
            foreach (q[i]) q[i].stale = 1'b1;
            exp_pc = redir_pc;
            fpc_m  = redir_pc;
        end
        prev_stall  = imem_req_o && !imem_gnt_i;
        prev_addr   = imem_addr_o;
        first_cycle = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    // Asynchronous reset (memory included), reset-value checks, release.
    task automatic do_reset();
        rst_n         = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_valid", if_valid_o, 1'b0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_instr", if_instr_o, NOP);
        q.delete();
        buffered   = 0;
        exp_pc     = RESET_PC;
        fpc_m      = RESET_PC;
        prev_stall = 0;
        redir      = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n       = 1'b1;
        first_cycle = 1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int k;
        k = 0;
        while (!if_valid_o && k < max_cycles) begin
            cycle();
            k++;
        end
        check(tag, if_valid_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        int g0;
        logic [31:0] tmp;
        rst_n = 1'b1;
        @(negedge clk_i);

        // Streaming: gnt=1, 1-cycle latency, ready=1 -> one instruction per cycle.
        do_reset();
        rdy = 1; gnt_force = 1; lat_min = 1; lat_max = 1;
        k = 0;
        while (popped == 0 && k < 20) begin cycle(); k++; end
        check("t1_first_pop", popped > 0, 1'b1);
        p0 = popped;
        repeat (10) cycle();
        check("t1_throughput", popped - p0, 10);

        // Decode stall from reset: credits fill, head holds RESET_PC.
        do_reset();
        rdy = 0;
        g0 = grants;
        repeat (10) cycle();
        check("t2_grants", grants - g0, DEPTH);
        check("t2_req_low", imem_req_o, 1'b0);
        check("t2_head_valid", if_valid_o, 1'b1);
        check("t2_head_pc", if_pc_o, RESET_PC);
        rdy = 1;
        repeat (12) cycle();

        // Grant withheld: address held until accepted.
        do_reset();
        gnt_force = 1;
        g0 = grants;
        k = 0;
        while (grants == g0 && k < 10) begin cycle(); k++; end
        gnt_force = 0;
        for (int i = 0; i < 3; i++) begin
            check("t3_addr_hold", imem_addr_o, RESET_PC + 32'd4);
            cycle();
        end
        check("t3_addr_hold_end", imem_addr_o, RESET_PC + 32'd4);
        gnt_force = 1;
        cycle();
        check("t3_addr_adv", imem_addr_o, RESET_PC + 32'd8);
        repeat (8) cycle();

        // Redirect with two responses in flight (3-cycle latency).
        do_reset();
        lat_min = 3; lat_max = 3; gnt_force = 1;
        g0 = grants;
        k = 0;
        while (grants - g0 < 2 && k < 10) begin cycle(); k++; end
        gnt_force = 0;
        redir = 1; redir_pc = 32'h0000_2000;
        cycle();
        redir = 0; gnt_force = 1;
        wait_valid("t4_timeout", 30);
        check("t4_pc", if_pc_o, 32'h0000_2000);
        check("t4_instr", if_instr_o, memdata(32'h0000_2000));
        repeat (6) cycle();

        // Redirect coinciding with rvalid, gnt and pop in steady streaming.
        do_reset();
        lat_min = 1; lat_max = 1; gnt_force = 1; rdy = 1;
        repeat (8) cycle();
        redir = 1; redir_pc = 32'h0000_3000;
        cycle();
        redir = 0;
        check("t5_flushed", if_valid_o, 1'b0);
        k = 1;
        while (!if_valid_o && k < 20) begin cycle(); k++; end
        check("t5_latency", k, 3);
        check("t5_pc", if_pc_o, 32'h0000_3000);
        repeat (6) cycle();

        // Reset mid-stream with three responses in flight.
        do_reset();
        lat_min = 3; lat_max = 3;
        k = 0;
        while (q.size() < 3 && k < 20) begin cycle(); k++; end
        do_reset();
        lat_min = 1; lat_max = 1;
        wait_valid("t6_timeout", 20);
        check("t6_pc", if_pc_o, RESET_PC);
        repeat (6) cycle();

        // Randomized traffic: random gnt, ready, latency and redirects.
        do_reset();
        gnt_force = -1; lat_min = 1; lat_max = 4;
        p0 = popped;
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0 || i == 400 || i == 401) begin
                redir = 1;
                tmp = $urandom;
                tmp[1:0] = 2'b00;
                redir_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : tmp;
            end else begin
                redir = 0;
            end
            cycle();
        end
        redir = 0; rdy = 1; gnt_force = 1;
        repeat (30) cycle();
        check("t7_progress", popped - p0 > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
